// File: rtl/instr_fetch_queue_decoder.sv
// Instruction fetch front end: classifies 16-bit words, merges group 5 hi/imm pairs,
// tags each entry with its word address and buffers entries in a small FIFO for execute.
package pkg_instr_dec;
  typedef enum logic [2:0] {
    grp_unknown = 3'd0,
    grp_1       = 3'd1,
    grp_2       = 3'd2,
    grp_3       = 3'd3,
    grp_4       = 3'd4,
    grp_5       = 3'd5
  } instr_group;
endpackage

module instr_fetch_queue_decoder #(
  parameter int QUEUE_DEPTH = 4,
  parameter int PC_WIDTH    = 16,
  parameter bit GRP5_ENABLE = 1'b1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic                           flush,
  input  logic [PC_WIDTH-1:0]            flush_pc,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [15:0]                    in_word,
  output logic                           out_valid,
  input  logic                           out_ready,
  output pkg_instr_dec::instr_group      out_group,
  output logic [15:0]                    out_word_hi,
  output logic [15:0]                    out_word_lo,
  output logic                           out_two_word,
  output logic                           out_illegal,
  output logic [PC_WIDTH-1:0]            out_pc,
  output logic [$clog2(QUEUE_DEPTH):0]   queue_count
);
  import pkg_instr_dec::*;

  localparam int PW = $clog2(QUEUE_DEPTH);
  localparam int CW = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(QUEUE_DEPTH);

  typedef enum logic {S_HI, S_LO} state_e;

  typedef struct packed {
    instr_group          group;
    logic [15:0]         hi;
    logic [15:0]         lo;
    logic                two_word;
    logic                illegal;
    logic [PC_WIDTH-1:0] pc;
  } entry_t;

  function automatic instr_group classify(input logic [15:0] w);
    instr_group g;
    if (!w[15])                     g = grp_1;
    else if (!w[14])                g = grp_2;
    else if (w[15:12] == 4'b1100)   g = grp_3;
    else if (w[15:12] == 4'b1101)   g = grp_4;
    else if (w[15:10] == 6'b111000) g = grp_5;
    else                            g = grp_unknown;
    return g;
  endfunction

  state_e              state_q, state_d;
  logic [PC_WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [15:0]         hold_word_q, hold_word_d;
  logic [PC_WIDTH-1:0] hold_pc_q, hold_pc_d;
  logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;

  entry_t              mem [QUEUE_DEPTH];
  entry_t              push_entry;
  entry_t              head;
  instr_group          word_grp;
  logic                xfer;
  logic                push;
  logic                pop;

  always_comb begin
    in_ready   = !flush && (count_q < DEPTH_C);
    xfer       = in_valid && in_ready;
    pop        = (count_q != '0) && out_ready && !flush;
    word_grp   = classify(in_word);
    push       = 1'b0;

    push_entry          = '0;
    push_entry.group    = word_grp;
    push_entry.hi       = in_word;
    push_entry.illegal  = (word_grp == grp_unknown) || ((word_grp == grp_5) && !GRP5_ENABLE);
    push_entry.pc       = fetch_pc_q;

    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    hold_word_d = hold_word_q;
    hold_pc_d   = hold_pc_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;

    if (flush) begin
      // Flush drops everything, including a half-received group 5 instruction.
      state_d     = S_HI;
      fetch_pc_d  = flush_pc;
      hold_word_d = '0;
      hold_pc_d   = '0;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      count_d     = '0;
    end else begin
      if (xfer) begin
        fetch_pc_d = fetch_pc_q + PC_WIDTH'(1);
        if (state_q == S_HI) begin
          if (GRP5_ENABLE && (word_grp == grp_5)) begin
            hold_word_d = in_word;
            hold_pc_d   = fetch_pc_q;
            state_d     = S_LO;
          end else begin
            push = 1'b1;
          end
        end else begin
          // Immediate word is taken verbatim, never classified.
          push_entry          = '0;
          push_entry.group    = grp_5;
          push_entry.hi       = hold_word_q;
          push_entry.lo       = in_word;
          push_entry.two_word = 1'b1;
          push_entry.pc       = hold_pc_q;
          push                = 1'b1;
          state_d             = S_HI;
        end
      end
      if (push) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_HI;
      fetch_pc_q  <= '0;
      hold_word_q <= '0;
      hold_pc_q   <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      hold_word_q <= hold_word_d;
      hold_pc_q   <= hold_pc_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
    end
  end

  // Storage needs no reset: contents are only observed through a nonzero count.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= push_entry;
  end

  always_comb begin
    out_valid    = (count_q != '0);
    head         = out_valid ? mem[rd_ptr_q] : '0;
    out_group    = head.group;
    out_word_hi  = head.hi;
    out_word_lo  = head.lo;
    out_two_word = head.two_word;
    out_illegal  = head.illegal;
    out_pc       = head.pc;
    queue_count  = count_q;
  end

endmodule

// File: tb/tb_instr_fetch_queue_decoder.sv
// Bench for instr_fetch_queue_decoder: directed steps plus random traffic against a
// queue-based reference model; a second instance runs with group 5 merging disabled.
module tb_instr_fetch_queue_decoder;
  import pkg_instr_dec::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] flush_pc = '0;
  logic        in_valid = 1'b0;
  logic [15:0] in_word = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_two_word, out_illegal;
  instr_group  out_group;
  logic [15:0] out_word_hi, out_word_lo, out_pc;
  logic [2:0]  queue_count;

  logic        b_in_ready, b_out_valid, b_out_two_word, b_out_illegal;
  instr_group  b_out_group;
  logic [15:0] b_out_word_hi, b_out_word_lo, b_out_pc;
  logic [2:0]  b_queue_count;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int          grp;
    logic [15:0] hi;
    logic [15:0] lo;
    bit          tw;
    bit          ill;
    logic [15:0] pc;
  } exp_t;

  exp_t        q[$];
  logic [15:0] m_pc = '0;
  bit          m_pend = 1'b0;
  logic [15:0] m_hold_w = '0;
  logic [15:0] m_hold_pc = '0;

  always #5 clk = ~clk;

  instr_fetch_queue_decoder #(.QUEUE_DEPTH(4), .PC_WIDTH(16), .GRP5_ENABLE(1'b1)) dut (
    .clk(clk), .reset_n(reset_n), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(in_ready), .in_word(in_word),
    .out_valid(out_valid), .out_ready(out_ready), .out_group(out_group),
    .out_word_hi(out_word_hi), .out_word_lo(out_word_lo), .out_two_word(out_two_word),
    .out_illegal(out_illegal), .out_pc(out_pc), .queue_count(queue_count)
  );

  instr_fetch_queue_decoder #(.QUEUE_DEPTH(4), .PC_WIDTH(16), .GRP5_ENABLE(1'b0)) dut_nog5 (
    .clk(clk), .reset_n(reset_n), .flush(flush), .flush_pc(flush_pc),
    .in_valid(in_valid), .in_ready(b_in_ready), .in_word(in_word),
    .out_valid(b_out_valid), .out_ready(out_ready), .out_group(b_out_group),
    .out_word_hi(b_out_word_hi), .out_word_lo(b_out_word_lo), .out_two_word(b_out_two_word),
    .out_illegal(b_out_illegal), .out_pc(b_out_pc), .queue_count(b_queue_count)
  );

  // Group ranges follow directly from the opcode prefixes.
  function automatic int classify_ref(input logic [15:0] w);
    if (w < 16'h8000) return 1;
    if (w < 16'hC000) return 2;
    if (w < 16'hD000) return 3;
    if (w < 16'hE000) return 4;
    if (w < 16'hE400) return 5;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_outputs();
    chk("out_valid", 32'(out_valid), 32'(q.size() != 0));
    chk("queue_count", 32'(queue_count), 32'(q.size()));
    if (q.size() != 0) begin
      chk("out_group", 32'(out_group), 32'(q[0].grp));
      chk("out_word_hi", 32'(out_word_hi), 32'(q[0].hi));
      chk("out_word_lo", 32'(out_word_lo), 32'(q[0].lo));
      chk("out_two_word", 32'(out_two_word), 32'(q[0].tw));
      chk("out_illegal", 32'(out_illegal), 32'(q[0].ill));
      chk("out_pc", 32'(out_pc), 32'(q[0].pc));
    end
  endtask

  task automatic check_reset_state();
    chk("rst_count", 32'(queue_count), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_hi", 32'(out_word_hi), 32'd0);
    chk("rst_lo", 32'(out_word_lo), 32'd0);
    chk("rst_pc", 32'(out_pc), 32'd0);
    chk("rst_group", 32'(out_group), 32'd0);
    chk("rst_flags", 32'({out_two_word, out_illegal}), 32'd0);
  endtask

  task automatic model_clear();
    q.delete();
    m_pc = '0;
    m_pend = 1'b0;
  endtask

  // Called at a falling edge; applies inputs for one clock and checks the result.
  task automatic cycle(input bit v, input logic [15:0] w, input bit ordy,
                       input bit fl, input logic [15:0] fpc);
    bit xfer, pop, exp_rdy;
    int g;
    in_valid = v; in_word = w; out_ready = ordy; flush = fl; flush_pc = fpc;
    #1;
    exp_rdy = !fl && (q.size() < 4);
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    xfer = v && exp_rdy;
    pop  = (q.size() != 0) && ordy && !fl;
    @(posedge clk);
    if (fl) begin
      q.delete();
      m_pend = 1'b0;
      m_pc = fpc;
    end else begin
      if (pop) void'(q.pop_front());
      if (xfer) begin
        if (m_pend) begin
          q.push_back('{5, m_hold_w, w, 1'b1, 1'b0, m_hold_pc});
          m_pend = 1'b0;
        end else begin
          g = classify_ref(w);
          if (g == 5) begin
            m_pend = 1'b1; m_hold_w = w; m_hold_pc = m_pc;
          end else begin
            q.push_back('{g, w, 16'h0, 1'b0, (g == 0), m_pc});
          end
        end
        m_pc = m_pc + 16'd1;
      end
    end
    @(negedge clk);
    check_outputs();
    $display("cycle v=%0d w=%h rdy=%0d fl=%0d -> out_valid=%0d grp=%0d pc=%h count=%0d",
             v, w, ordy, fl, out_valid, out_group, out_pc, queue_count);
  endtask

  task automatic do_reset();
    @(negedge clk);
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  function automatic logic [15:0] rand_word();
    case ($urandom_range(0, 5))
      0: return 16'($urandom) & 16'h7FFF;
      1: return 16'h8000 | (16'($urandom) & 16'h3FFF);
      2: return 16'hC000 | (16'($urandom) & 16'h0FFF);
      3: return 16'hD000 | (16'($urandom) & 16'h0FFF);
      4: return 16'hE000 | (16'($urandom) & 16'h03FF);
      default: return 16'hE400 + 16'($urandom_range(0, 16'h1BFF));
    endcase
  endfunction

  initial begin
    #3 check_reset_state();
    @(negedge clk);
    reset_n = 1'b1;

    // Four single-word groups at pc 0..3.
    cycle(1, 16'h1234, 1, 0, 0);
    chk("first_grp1", 32'(out_group), 32'(grp_1));
    chk("first_pc0", 32'(out_pc), 32'd0);
    cycle(1, 16'h8A5B, 1, 0, 0);
    cycle(1, 16'hC3FF, 1, 0, 0);
    cycle(1, 16'hD07E, 1, 0, 0);
    chk("fourth_grp4", 32'(out_group), 32'(grp_4));
    cycle(0, 16'h0, 1, 0, 0);

    // Two-word group 5, then unknown; second instance flags group 5 alone.
    do_reset();
    cycle(1, 16'hE0AB, 1, 0, 0);
    chk("g5_not_yet", 32'(out_valid), 32'd0);
    chk("nog5_valid", 32'(b_out_valid), 32'd1);
    chk("nog5_group", 32'(b_out_group), 32'(grp_5));
    chk("nog5_illegal", 32'(b_out_illegal), 32'd1);
    chk("nog5_two_word", 32'(b_out_two_word), 32'd0);
    chk("nog5_pc", 32'(b_out_pc), 32'd0);
    cycle(1, 16'h55AA, 1, 0, 0);
    chk("g5_lo", 32'(out_word_lo), 32'h55AA);
    cycle(1, 16'hF000, 1, 0, 0);
    chk("unk_pc2", 32'(out_pc), 32'd2);
    chk("unk_illegal", 32'(out_illegal), 32'd1);
    cycle(0, 16'h0, 1, 0, 0);

    // Fill to full with out_ready low, then pop, push+pop, drain across the wrap.
    for (int i = 0; i < 6; i++) cycle(1, 16'h0100 + 16'(i), 0, 0, 0);
    chk("full_count", 32'(queue_count), 32'd4);
    cycle(0, 16'h0, 1, 0, 0);
    chk("pop_count3", 32'(queue_count), 32'd3);
    cycle(1, 16'h0200, 1, 0, 0);
    chk("pushpop_count3", 32'(queue_count), 32'd3);
    for (int i = 0; i < 3; i++) cycle(1, 16'h0300 + 16'(i), 1, 0, 0);
    for (int i = 0; i < 4; i++) cycle(0, 16'h0, 1, 0, 0);

    // Flush discards a pending group 5 hi word.
    cycle(1, 16'hE0AB, 1, 0, 0);
    cycle(1, 16'h1234, 1, 1, 16'h0100);
    chk("flush_empty", 32'(out_valid), 32'd0);
    cycle(1, 16'h0001, 1, 0, 0);
    chk("flush_pc", 32'(out_pc), 32'h0100);
    chk("flush_grp1", 32'(out_group), 32'(grp_1));
    cycle(0, 16'h0, 1, 0, 0);

    // Random traffic with occasional flushes.
    for (int i = 0; i < 400; i++) begin
      cycle($urandom_range(0, 3) != 0, rand_word(), $urandom_range(0, 9) < 7,
            $urandom_range(0, 39) == 0, 16'($urandom));
    end

    // Asynchronous reset with entries queued and a group 5 hi word pending.
    do_reset();
    for (int i = 0; i < 3; i++) cycle(1, 16'h0010 + 16'(i), 0, 0, 0);
    cycle(1, 16'hE1FF, 0, 0, 0);
    chk("pre_rst_count", 32'(queue_count), 32'd3);
    in_valid = 1'b0;
    #2 reset_n = 1'b0;
    #1 check_reset_state();
    model_clear();
    @(negedge clk);
    reset_n = 1'b1;
    cycle(1, 16'h0001, 1, 0, 0);
    chk("post_rst_pc0", 32'(out_pc), 32'd0);
    cycle(0, 16'h0, 1, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue_decoder.md
Name: instr_fetch_queue_decoder

Overview:
- Sequential front end between instruction fetch and execute.
- Accepts a stream of 16-bit instruction words over a valid/ready handshake.
- Classifies each instruction into groups 1-5 or unknown, and merges group 5 two-word instructions (hi word + immediate word) into one entry.
- Tags each entry with its word address and buffers entries in a parametrised FIFO for the execute stage.
- Execute feeds the existing per-group combinational decoders from the queued hi/lo words.

Parameters:
- QUEUE_DEPTH, 4, number of decoded-instruction entries buffered; power of two, 2..16.
- PC_WIDTH, 16, width of the word-address counter.
- GRP5_ENABLE, 1, 1 = group 5 takes a second word; 0 = group 5 hi word is flagged illegal and queued alone.

Ports:
- clk  in  1  clock, all state on rising edge.
- reset_n  in  1  asynchronous active-low reset.
- flush  in  1  discard queue and partial instruction, restart at flush_pc.
- flush_pc  in  PC_WIDTH  new word address, loaded on flush.
- in_valid  in  1  fetch word valid.
- in_ready  out  1  block can accept a word this cycle.
- in_word  in  16  instruction word.
- out_valid  out  1  queue head valid.
- out_ready  in  1  execute pops the head.
- out_group  out  3  pkg_instr_dec::instr_group of the head.
- out_word_hi  out  16  first word of the head.
- out_word_lo  out  16  second word (group 5); 0 otherwise.
- out_two_word  out  1  head is a two-word instruction.
- out_illegal  out  1  head group unknown, or group 5 with GRP5_ENABLE=0.
- out_pc  out  PC_WIDTH  address of the head's hi word.
- queue_count  out  $clog2(QUEUE_DEPTH)+1  occupied entries.

Behaviour:
Reset (async, reset_n low):
- State S_HI; fetch_pc=0; queue empty.
- Outputs: queue_count=0, out_valid=0, in_ready=1.
- Head data outputs read 0.

Group classification on hi word, priority order:
- bit15=0 -> grp_1
- [15:14]=10 -> grp_2
- [15:12]=1100 -> grp_3
- [15:12]=1101 -> grp_4
- [15:10]=111000 -> grp_5
- otherwise -> grp_unknown, with illegal=1.

Input handshake:
- A word transfers when in_valid && in_ready.
- in_ready = !flush && (queue_count < QUEUE_DEPTH).
- in_ready is combinational from registered count and flush.

fetch_pc:
- Increments by 1 (mod 2^PC_WIDTH) per transferred word.
- On flush, loads flush_pc.

State S_HI, word transferred:
- Non-grp_5, or grp_5 with GRP5_ENABLE=0:
  - Push {group, hi=word, lo=0, two_word=0, illegal, pc=fetch_pc}.
  - Stay in S_HI.
- grp_5 with GRP5_ENABLE=1:
  - Latch hold_word=word and hold_pc=fetch_pc.
  - Go to S_LO; nothing pushed.

State S_LO, word transferred:
- Push {grp_5, hi=hold_word, lo=word, two_word=1, illegal=0, pc=hold_pc}.
- Go to S_HI.
- The second word is never classified.

Output side:
- Registered FIFO, no bypass. A push at edge N is visible at the head after edge N (latency 1 cycle from the final word's transfer).
- Pop when out_valid && out_ready.

Occupancy:
- Push and pop in the same cycle: count unchanged, both take effect.
- When full, in_ready=0.
- A pop at full raises in_ready the next cycle, not the same cycle.

Pointers:
- Read/write pointers wrap modulo QUEUE_DEPTH.
- Count distinguishes full from empty.

flush (synchronous, highest priority):
- Next edge: queue emptied, state S_HI, fetch_pc=flush_pc, hold registers cleared.
- The in_word presented in the flush cycle is not transferred (in_ready=0).
- A pop in the flush cycle is ignored.
- out_valid=0 the cycle after the flush.

Partial instruction:
- A group 5 hi word waiting in S_LO is discarded by flush or reset.
- Its pc is never reported.

Stability:
- out_* stable while out_valid && !out_ready.
- in_word is ignored when in_valid=0.

Test Plan:
- Reset, then words 0x1234, 0x8A5B, 0xC3FF, 0xD07E at fetch_pc 0 with out_ready=1 -> four entries:
  - groups grp_1, grp_2, grp_3, grp_4;
  - pc 0..3, two_word=0, lo=0;
  - each out_valid one cycle after its transfer.
- Word 0xE0AB then 0x55AA -> one entry: grp_5, hi=0xE0AB, lo=0x55AA, two_word=1, pc=0; out_valid only after the second transfer; next pc=2.
- Word 0xF000 -> grp_unknown, illegal=1, pc advances by 1. Repeat 0xE0AB with GRP5_ENABLE=0 -> illegal=1, two_word=0.
- QUEUE_DEPTH=4, out_ready=0, push 6 words:
  - in_ready falls after 4 pushes, queue_count=4, no overwrite.
  - Pop one with out_ready=1 -> count 3.
  - Simultaneous push+pop holds count.
  - Pointer wrap shows correct FIFO order.
- Send 0xE0AB, then flush with flush_pc=0x0100, then 0x0001:
  - no grp_5 entry appears;
  - entry grp_1 with pc=0x0100;
  - queue empty the cycle after the flush.
- Assert reset_n low mid-stream with 3 entries queued and S_LO pending -> immediately count=0, out_valid=0; after release, the first word gets pc=0.
